// File: rtl/udp_cmd_rx.sv
// udp_cmd_rx: parses 8-byte host command datagrams into capture control.
// Optional UDP_CMD_STATS_EN adds saturating good/bad frame counters.
module udp_cmd_rx #(
  parameter logic [15:0] CMD_PORT     = 16'd5000,
  parameter logic [15:0] MAGIC        = 16'hADC0,
  parameter logic [5:0]  DEFAULT_MASK = 6'h3F,
  parameter logic [15:0] DEFAULT_PKTS = 16'd1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        udp_hdr_valid,
  output logic        udp_hdr_ready,
  input  logic [15:0] udp_dest_port,
  input  logic [15:0] udp_length,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        start,
  output logic        soft_rst,
  output logic [5:0]  ch_mask,
  output logic [15:0] pkt_count,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  typedef enum logic [1:0] {
    IDLE, PAYLOAD, DROP, EXEC
  } state_t;

  state_t      state_q, state_n;
  logic [63:0] sr_q, sr_n;
  logic [2:0]  idx_q, idx_n;
  logic        hdr_rdy_q, tready_q;
  logic        start_q, start_n;
  logic        soft_q, soft_n;
  logic [5:0]  mask_q, mask_n;
  logic [15:0] pkts_q, pkts_n;
  logic        good_inc, bad_inc;

  logic        hdr_hs, beat;
  logic        magic_ok;
  logic [7:0]  op;
  logic [31:0] arg;
  logic        cmd_start, cmd_mask;
  logic        cmd_pkts, cmd_srst;

  assign hdr_hs = udp_hdr_valid & hdr_rdy_q;
  assign beat   = s_axis_tvalid & tready_q;

  assign magic_ok  = sr_q[63:48] == MAGIC;
  assign op        = sr_q[47:40];
  assign arg       = sr_q[31:0];
  assign cmd_start = magic_ok && op == 8'h01;
  assign cmd_mask  = magic_ok && op == 8'h02;
  assign cmd_pkts  = magic_ok && op == 8'h03;
  assign cmd_srst  = magic_ok && op == 8'h04;

  always_comb begin
    state_n  = state_q;
    sr_n     = sr_q;
    idx_n    = idx_q;
    start_n  = 1'b0;
    soft_n   = 1'b0;
    mask_n   = mask_q;
    pkts_n   = pkts_q;
    good_inc = 1'b0;
    bad_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hdr_hs) begin
          if (udp_dest_port != CMD_PORT) begin
            state_n = DROP;
          end else if (udp_length == 16'd16) begin
            state_n = PAYLOAD;
            idx_n   = 3'd0;
          end else begin
            state_n = DROP;
            bad_inc = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (beat) begin
          sr_n  = {sr_q[55:0], s_axis_tdata};
          idx_n = idx_q + 3'd1;
          unique case (1'b1)
            s_axis_tuser: begin
              bad_inc = 1'b1;
              state_n = s_axis_tlast ? IDLE : DROP;
            end
            !s_axis_tuser && s_axis_tlast
              && idx_q == 3'd7: begin
              state_n = EXEC;
            end
            !s_axis_tuser && s_axis_tlast
              && idx_q != 3'd7: begin
              bad_inc = 1'b1;
              state_n = IDLE;
            end
            !s_axis_tuser && !s_axis_tlast
              && idx_q == 3'd7: begin
              bad_inc = 1'b1;
              state_n = DROP;
            end
            default: ;
          endcase
        end
      end
      DROP: begin
        if (beat && s_axis_tlast) begin
          state_n = IDLE;
        end
      end
      EXEC: begin
        state_n = IDLE;
        unique case (1'b1)
          cmd_start: begin
            start_n  = 1'b1;
            good_inc = 1'b1;
          end
          cmd_mask: begin
            if (arg[5:0] != 6'd0) begin
              mask_n   = arg[5:0];
              good_inc = 1'b1;
            end else begin
              bad_inc = 1'b1;
            end
          end
          cmd_pkts: begin
            if (arg[15:0] != 16'd0) begin
              pkts_n   = arg[15:0];
              good_inc = 1'b1;
            end else begin
              bad_inc = 1'b1;
            end
          end
          cmd_srst: begin
            soft_n   = 1'b1;
            good_inc = 1'b1;
          end
          default: bad_inc = 1'b1;
        endcase
      end
      default: state_n = IDLE;
    endcase
  end

  // readies track the next state so they are valid the cycle it is entered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      idx_q     <= '0;
      hdr_rdy_q <= 1'b1;
      tready_q  <= 1'b0;
      start_q   <= 1'b0;
      soft_q    <= 1'b0;
      mask_q    <= DEFAULT_MASK;
      pkts_q    <= DEFAULT_PKTS;
    end else begin
      state_q   <= state_n;
      sr_q      <= sr_n;
      idx_q     <= idx_n;
      hdr_rdy_q <= state_n == IDLE;
      tready_q  <= state_n == PAYLOAD
                || state_n == DROP;
      start_q   <= start_n;
      soft_q    <= soft_n;
      mask_q    <= mask_n;
      pkts_q    <= pkts_n;
    end
  end

  assign udp_hdr_ready = hdr_rdy_q;
  assign s_axis_tready = tready_q;
  assign start         = start_q;
  assign soft_rst      = soft_q;
  assign ch_mask       = mask_q;
  assign pkt_count     = pkts_q;

`ifdef UDP_CMD_STATS_EN
  logic [15:0] good_q, bad_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      if (good_inc && good_q != 16'hFFFF) begin
        good_q <= good_q + 16'd1;
      end
      if (bad_inc && bad_q != 16'hFFFF) begin
        bad_q <= bad_q + 16'd1;
      end
    end
  end

  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;
`else
  logic stats_unused;

  assign stats_unused = good_inc ^ bad_inc;
  assign good_cnt     = '0;
  assign bad_cnt      = '0;
`endif

endmodule

// File: tb/tb_udp_cmd_rx.sv
// tb_udp_cmd_rx: directed command frames against udp_cmd_rx.
// Counter expectations follow UDP_CMD_STATS_EN.
module tb_udp_cmd_rx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        udp_hdr_valid = 1'b0;
  logic        udp_hdr_ready;
  logic [15:0] udp_dest_port = '0;
  logic [15:0] udp_length = '0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        start;
  logic        soft_rst;
  logic [5:0]  ch_mask;
  logic [15:0] pkt_count;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  udp_cmd_rx dut (
    .clk           (clk),
    .rstn          (rstn),
    .udp_hdr_valid (udp_hdr_valid),
    .udp_hdr_ready (udp_hdr_ready),
    .udp_dest_port (udp_dest_port),
    .udp_length    (udp_length),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .start         (start),
    .soft_rst      (soft_rst),
    .ch_mask       (ch_mask),
    .pkt_count     (pkt_count),
    .good_cnt      (good_cnt),
    .bad_cnt       (bad_cnt)
  );

  always #4 clk = ~clk;

  int     n_total = 0;
  int     n_bad   = 0;
  int     start_seen = 0;
  int     soft_seen  = 0;
  longint t_start = 0;
  longint t_hs    = 0;
  logic [7:0] pl [16];

  always @(negedge clk) begin
    if (start) begin
      start_seen++;
      t_start = $time;
    end
    if (soft_rst) soft_seen++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] scnt(input int v);
`ifdef UDP_CMD_STATS_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [15:0] port,
                          input logic [15:0] len);
    logic hs;
    @(negedge clk);
    udp_hdr_valid = 1'b1;
    udp_dest_port = port;
    udp_length    = len;
    for (int i = 0; i < 40; i++) begin
      hs = udp_hdr_ready;
      @(posedge clk);
      if (hs) break;
      @(negedge clk);
      if (i == 39) check("hdr_timeout", 0, 1);
    end
    @(negedge clk);
    udp_hdr_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d,
                           input logic last,
                           input logic user);
    logic hs;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    for (int i = 0; i < 40; i++) begin
      hs = s_axis_tready;
      @(posedge clk);
      if (hs) begin
        t_hs = $time;
        break;
      end
      @(negedge clk);
      if (i == 39) check("beat_timeout", 0, 1);
    end
  endtask

  task automatic send_frame(input logic [15:0] port,
                            input logic [15:0] len,
                            input int n,
                            input int user_at);
    send_hdr(port, len);
    for (int i = 0; i < n; i++) begin
      send_byte(pl[i], i == n - 1, i == user_at);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    idle(6);
  endtask

  task automatic load_cmd(input logic [15:0] mg,
                          input logic [7:0] op,
                          input logic [31:0] arg);
    pl[0] = mg[15:8];
    pl[1] = mg[7:0];
    pl[2] = op;
    pl[3] = 8'h00;
    pl[4] = arg[31:24];
    pl[5] = arg[23:16];
    pl[6] = arg[15:8];
    pl[7] = arg[7:0];
    for (int i = 8; i < 16; i++) pl[i] = 8'h00;
  endtask

  initial begin
    idle(3);
    check("rst_start", 32'(start), 0);
    check("rst_soft", 32'(soft_rst), 0);
    check("rst_mask", 32'(ch_mask), 32'h3F);
    check("rst_pkts", 32'(pkt_count), 1);
    check("rst_good", 32'(good_cnt), 0);
    check("rst_bad", 32'(bad_cnt), 0);
    check("rst_hdr_rdy", 32'(udp_hdr_ready), 1);
    check("rst_tready", 32'(s_axis_tready), 0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);
    check("idle_tready", 32'(s_axis_tready), 0);

    load_cmd(16'hADC0, 8'h01, 32'h0);
    send_frame(16'd5000, 16'd16, 8, -1);
    check("start_cnt1", 32'(start_seen), 1);
    check("start_lat", 32'(t_start - t_hs), 12);
    check("good1", 32'(good_cnt), scnt(1));

    load_cmd(16'hADC0, 8'h02, 32'h5);
    send_frame(16'd5000, 16'd16, 8, -1);
    check("mask05", 32'(ch_mask), 32'h05);
    check("mask_nostart", 32'(start_seen), 1);

    load_cmd(16'hADC0, 8'h03, 32'h100);
    send_frame(16'd5000, 16'd16, 8, -1);
    check("pkts0100", 32'(pkt_count), 32'h0100);
    check("pkts_nostart", 32'(start_seen), 1);
    check("good3", 32'(good_cnt), scnt(3));

    load_cmd(16'hADC1, 8'h01, 32'h0);
    send_frame(16'd5000, 16'd16, 8, -1);
    check("magic_nostart", 32'(start_seen), 1);
    check("magic_bad", 32'(bad_cnt), scnt(1));

    load_cmd(16'hADC0, 8'h01, 32'h0);
    send_frame(16'd5001, 16'd16, 8, -1);
    check("port_nostart", 32'(start_seen), 1);
    check("port_bad", 32'(bad_cnt), scnt(1));
    check("port_good", 32'(good_cnt), scnt(3));

    send_frame(16'd5000, 16'd16, 5, -1);
    check("short_bad", 32'(bad_cnt), scnt(2));
    send_frame(16'd5000, 16'd16, 12, -1);
    check("long_bad", 32'(bad_cnt), scnt(3));
    send_frame(16'd5000, 16'd20, 12, -1);
    check("len_bad", 32'(bad_cnt), scnt(4));
    check("len_nostart", 32'(start_seen), 1);

    send_frame(16'd5000, 16'd16, 8, -1);
    check("start_cnt2", 32'(start_seen), 2);
    check("start_lat2", 32'(t_start - t_hs), 12);
    check("good4", 32'(good_cnt), scnt(4));

    send_frame(16'd5000, 16'd16, 8, 7);
    check("tuser_last", 32'(start_seen), 2);
    check("tuser_bad", 32'(bad_cnt), scnt(5));
    send_frame(16'd5000, 16'd16, 8, 2);
    check("tuser_mid", 32'(start_seen), 2);
    check("tuser_mid_bad", 32'(bad_cnt), scnt(6));

    load_cmd(16'hADC0, 8'h02, 32'h0);
    send_frame(16'd5000, 16'd16, 8, -1);
    check("mask0_keep", 32'(ch_mask), 32'h05);
    check("mask0_bad", 32'(bad_cnt), scnt(7));

    load_cmd(16'hADC0, 8'h04, 32'h0);
    send_frame(16'd5000, 16'd16, 8, -1);
    check("srst_cnt", 32'(soft_seen), 1);
    check("srst_mask", 32'(ch_mask), 32'h05);
    check("srst_pkts", 32'(pkt_count), 32'h0100);
    check("srst_nostart", 32'(start_seen), 2);
    check("good5", 32'(good_cnt), scnt(5));

    load_cmd(16'hADC0, 8'h07, 32'h0);
    send_frame(16'd5000, 16'd16, 8, -1);
    check("badop", 32'(bad_cnt), scnt(8));
    load_cmd(16'hADC0, 8'h03, 32'h0);
    send_frame(16'd5000, 16'd16, 8, -1);
    check("pkts0_keep", 32'(pkt_count), 32'h0100);
    check("pkts0_bad", 32'(bad_cnt), scnt(9));

    load_cmd(16'hADC0, 8'h01, 32'h0);
    send_hdr(16'd5000, 16'd16);
    for (int i = 0; i < 4; i++) send_byte(pl[i], 1'b0, 1'b0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    rstn = 1'b0;
    #1;
    check("mrst_mask", 32'(ch_mask), 32'h3F);
    check("mrst_pkts", 32'(pkt_count), 1);
    check("mrst_good", 32'(good_cnt), 0);
    check("mrst_bad", 32'(bad_cnt), 0);
    check("mrst_tready", 32'(s_axis_tready), 0);
    idle(3);
    rstn = 1'b1;
    idle(6);
    check("mrst_nostart", 32'(start_seen), 2);

    send_frame(16'd5000, 16'd16, 8, -1);
    check("post_start", 32'(start_seen), 3);
    check("post_good", 32'(good_cnt), scnt(1));
    load_cmd(16'hADC0, 8'h02, 32'h2A);
    send_frame(16'd5000, 16'd16, 8, -1);
    check("post_mask", 32'(ch_mask), 32'h2A);
    check("post_bad", 32'(bad_cnt), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/udp_cmd_rx.md
Name: udp_cmd_rx

Overview:
- Host-command receiver on the UDP RX side of `eth` (consumes udp_hdr_* and rx_udp_payload_axis_*).
- Parses fixed 8-byte command datagrams from the host PC.
- Drives the capture `start` pulse, channel-enable mask, packets-per-capture count and a soft-reset pulse toward the write/read controllers.
- Lives entirely in the 125 MHz logic domain.

Parameters:
- CMD_PORT, 16'd5000: UDP destination port that carries commands.
- MAGIC, 16'hADC0: required first two payload bytes, big-endian.
- DEFAULT_MASK, 6'h3F: reset value of ch_mask (bit0=adc1 … bit3=adc4, bit4=adc7, bit5=adc8).
- DEFAULT_PKTS, 16'd1: reset value of pkt_count.

Ports:
- clk  in  1  125 MHz logic clock.
- rstn  in  1  asynchronous active-low reset.
- udp_hdr_valid  in  1  RX UDP header valid.
- udp_hdr_ready  out  1  header accept.
- udp_dest_port  in  16  header destination port.
- udp_length  in  16  UDP length in bytes, including the 8-byte UDP header.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  payload valid.
- s_axis_tready  out  1  payload ready.
- s_axis_tlast  in  1  last payload byte.
- s_axis_tuser  in  1  frame error flag, sampled on any beat.
- start  out  1  one-cycle capture trigger.
- soft_rst  out  1  one-cycle buffer/controller flush.
- ch_mask  out  6  channel enable mask.
- pkt_count  out  16  UDP packets per capture.
- good_cnt  out  16  accepted commands (see optional feature).
- bad_cnt  out  16  rejected frames (see optional feature).

Behaviour:
- Reset (async, rstn=0):
  - State IDLE.
  - start=0, soft_rst=0, ch_mask=DEFAULT_MASK, pkt_count=DEFAULT_PKTS, counters=0, shift register=0.
- Frame format, 8 bytes, big-endian: MAGIC[15:8], MAGIC[7:0], opcode, reserved (ignored), arg[31:24] … arg[7:0].
- States IDLE, PAYLOAD, DROP, EXEC. Ready outputs are registered and decoded from state.
- IDLE:
  - udp_hdr_ready=1, s_axis_tready=0. Payload arriving before a header stalls.
  - On header handshake: go to PAYLOAD with byte index=0 if udp_dest_port==CMD_PORT and udp_length==16; otherwise go to DROP.
- PAYLOAD:
  - s_axis_tready=1. Each accepted beat shifts into a 64-bit register and increments the 3-bit index.
  - Beat with tlast at index 7 → EXEC.
  - tlast at index <7 → bad frame, return to IDLE.
  - Index 7 without tlast → bad frame, go to DROP.
  - tuser=1 on any beat: mark frame bad. At tlast go to IDLE without executing; otherwise go to DROP.
- DROP:
  - s_axis_tready=1. Discard beats until the tlast beat, then go to IDLE.
  - Frames dropped for port mismatch are not counted. All other drops increment bad_cnt once per frame.
- EXEC (exactly one cycle, both readies 0): check magic, decode opcode, then return to IDLE.
  - 0x01 START: start=1 for one cycle.
  - 0x02 SET_MASK: ch_mask←arg[5:0]. arg[5:0]==0 is rejected as bad.
  - 0x03 SET_PKTS: pkt_count←arg[15:0]. Zero is rejected as bad.
  - 0x04 SOFT_RST: soft_rst=1 for one cycle. ch_mask and pkt_count are unchanged.
  - Bad magic or any other opcode → bad, no side effect.
- Latency: start, soft_rst and register updates appear 2 cycles after the tlast beat handshake (EXEC cycle plus output register). Pulses are registered outputs.
- Back-to-back frames:
  - A new header is accepted no earlier than the cycle after EXEC or DROP exits.
  - tvalid gaps are legal in any state.
- Mid-frame reset aborts parsing immediately. No pulse is emitted for the aborted frame.

Optional Feature:
- UDP_CMD_STATS_EN defined: good_cnt increments on every accepted command; bad_cnt increments per rejected frame. Both saturate at 16'hFFFF.
- Undefined: good_cnt and bad_cnt are constant 0 and no counter logic is synthesised.

Test Plan:
- Port 5000, len 16, payload AD C0 01 00 00 00 00 00 → start high exactly 1 cycle, 2 cycles after the tlast handshake; good_cnt=1.
- Payload AD C0 02 00 00 00 00 05 → ch_mask=6'h05. Then AD C0 03 00 00 00 01 00 → pkt_count=16'h0100. No start pulse for either.
- Payload AD C1 01 00 00 00 00 00 → no start; bad_cnt=1. Port 5001 with any payload → frame consumed, counters unchanged.
- Port 5000 frames of 5 bytes and of 12 bytes (tlast at beat 12) → both consumed fully, bad_cnt+=2. A following valid START frame is still executed.
- Valid START frame with tuser=1 on the tlast beat → no start; bad_cnt+1. SET_MASK with arg 0 → ch_mask unchanged; bad_cnt+1.
- Deassert rstn after the 4th payload byte of a START frame → all outputs return to reset values, start never pulses. The next full frame parses correctly.
